// File: rtl/uart_pkg.sv
// Shared UART encodings: frame modes common to TX and RX, TX state encoding,
// oversample and stop-length tick constants.
package uart_pkg;

  typedef enum logic [2:0] {
    D5P0 = 3'b000, D5P1 = 3'b001, D6P0 = 3'b010, D6P1 = 3'b011,
    D7P0 = 3'b100, D7P1 = 3'b101, D8P0 = 3'b110, D8P1 = 3'b111
  } umode_e;

  typedef enum logic [1:0] {
    STP_1B  = 2'b00,
    STP_15B = 2'b01,
    STP_2B  = 2'b10,
    STP_1BX = 2'b11
  } smode_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE
  } tx_state_e;

  localparam int unsigned OVS_TICKS     = 8;
  localparam int unsigned STOP_TICKS_1  = 8;
  localparam int unsigned STOP_TICKS_15 = 12;
  localparam int unsigned STOP_TICKS_2  = 16;

  localparam logic [3:0] BIT_TICK_TERM = 4'(OVS_TICKS - 1);

  // Tick-counter terminal value for the stop field.
  function automatic logic [3:0] stop_term_of(input logic [1:0] smode);
    case (smode)
      STP_15B: return 4'(STOP_TICKS_15 - 1);
      STP_2B:  return 4'(STOP_TICKS_2 - 1);
      default: return 4'(STOP_TICKS_1 - 1);
    endcase
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] width_sel);
    return 8'hFF >> (2'd3 - width_sel);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Character handshake into the UART transmitter, with the frame mode that
// travels alongside each character.
interface uart_tx_if;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] TX_DATA;
  logic [2:0] UMODE;
  logic [1:0] SMODE;

  modport master (output TX_VALID, TX_DATA, UMODE, SMODE, input TX_READY);
  modport slave  (input TX_VALID, TX_DATA, UMODE, SMODE, output TX_READY);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one 5-8 bit character per handshake, optional even parity, 1/1.5/2 stops.
// TX drops on the handshake edge; TX_READY is held low from handshake until the cycle after TX_DONE.
module uart_tx
  import uart_pkg::*;
(
  input  logic     SCLK,
  input  logic     SCLR_N,
  input  logic     BAUD_TICK,
  uart_tx_if.slave tx_if,
  output logic     TX,
  output logic     TX_BUSY,
  output logic     TX_DONE
);

  tx_state_e  state, state_nxt;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [2:0] last_bit;
  logic       par_en;
  logic       par_bit;
  logic [3:0] stop_term;
  logic       ready;
  logic       hs;
  logic       tick_in_bit;
  logic       bit_end;

  assign hs          = tx_if.TX_VALID && ready;
  assign tick_in_bit = BAUD_TICK && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
  assign bit_end     = tick_in_bit &&
                       (tick_cnt == ((state == ST_STOP) ? stop_term : BIT_TICK_TERM));
  assign tx_if.TX_READY = ready;

  always_ff @(posedge SCLK or negedge SCLR_N) begin
    if (!SCLR_N) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hs) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = ST_DATA;
      ST_DATA:   if (bit_end && bit_idx == last_bit)
                   state_nxt = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Frame parameters are captured at the handshake so later input changes
  // cannot disturb the frame in flight; parity is precomputed from the masked data.
  always_ff @(posedge SCLK or negedge SCLR_N) begin
    if (!SCLR_N) begin
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      last_bit  <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop_term <= '0;
    end else if (hs) begin
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= tx_if.TX_DATA;
      last_bit  <= {1'b1, tx_if.UMODE[2:1]};
      par_en    <= tx_if.UMODE[0];
      par_bit   <= ^(tx_if.TX_DATA & data_mask(tx_if.UMODE[2:1]));
      stop_term <= stop_term_of(tx_if.SMODE);
    end else if (bit_end) begin
      tick_cnt <= '0;
      if (state == ST_DATA) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= (bit_idx == last_bit) ? 3'd0 : bit_idx + 3'd1;
      end
    end else if (tick_in_bit) begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end

  always_comb begin
    TX      = 1'b1;
    TX_BUSY = 1'b1;
    TX_DONE = 1'b0;
    ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        TX_BUSY = 1'b0;
        ready   = 1'b1;
      end
      ST_START:  TX = 1'b0;
      ST_DATA:   TX = shift[0];
      ST_PARITY: TX = par_bit;
      ST_DONE:   TX_DONE = 1'b1;
      default:   TX = 1'b1;
    endcase
  end

endmodule
